brick_game_ctrl: RTL and testbench

- Frame-rate game controller directly downstream of the ball/brick collision stage.
- Consumes that stage's ball position, velocity feedback and per-brick existence vector.
- Closes the velocity loop, drives the stage's active-high reset to serve the ball, keeps score, lives and cleared-brick history, and runs the game state machine (idle, serve, play, lost ball, game over, win).

---
 rtl/brick_game_ctrl.sv | 152 +++++++++++++++
 tb/tb_brick_game_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/brick_game_ctrl.sv
// brick_game_ctrl: serve/play/lost/over/win game FSM closing the velocity loop of the brick collision stage.
// Define BRICK_GAME_BONUS_LIFE_EN to award a life for every fifth cleared brick.
module brick_game_ctrl #(
    parameter int NUM_BRICKS       = 10,
    parameter int START_LIVES      = 3,
    parameter int SERVE_DELAY      = 60,
    parameter int FLOOR_Y          = 470,
    parameter int POINTS_PER_BRICK = 10
) (
    input  logic                  frame_clk,
    input  logic                  Reset_n,
    input  logic                  start,
    input  logic [NUM_BRICKS-1:0] brick_exists,
    input  logic [9:0]            ball_y,
    input  logic [9:0]            ball_s,
    input  logic [1:0]            velocity_x_out,
    input  logic [1:0]            velocity_y_out,
    output logic [1:0]            velocity_x_in,
    output logic [1:0]            velocity_y_in,
    output logic                  ball_reset,
    output logic [15:0]           score,
    output logic [2:0]            lives,
    output logic [2:0]            state,
    output logic                  game_over,
    output logic                  game_won
);
    localparam int CW = $clog2(NUM_BRICKS + 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SERVE = 3'd1,
        PLAY = 3'd2,
        LOST = 3'd3,
        OVER = 3'd4,
        WIN = 3'd5
    } state_t;

    state_t                  st;
    logic [NUM_BRICKS-1:0]   cleared_mask, brick_prev, newly;
    logic                    start_prev, start_edge, all_clear, floor_hit;
    logic [7:0]              serve_timer;
    logic [CW-1:0]           n_new;
    logic [31:0]             score_sum;
    logic [15:0]             score_next;
    logic [10:0]             ball_bottom;
    logic [2:0]              play_lives;

    assign start_edge  = start & ~start_prev;
    // Re-appearing bricks stay masked, so only a first-ever fall scores.
    assign newly       = brick_prev & ~brick_exists & ~cleared_mask;
    assign all_clear   = &(cleared_mask | newly);
    assign ball_bottom = {1'b0, ball_y} + {1'b0, ball_s};
    assign floor_hit   = ball_bottom >= 11'(FLOOR_Y);
    assign score_sum   = 32'(score) + 32'(n_new) * 32'(POINTS_PER_BRICK);
    assign score_next  = score_sum > 32'h0000_FFFF ? 16'hFFFF : score_sum[15:0];
    assign state       = st;
    assign game_over   = st == OVER;
    assign game_won    = st == WIN;

    always_comb begin
        n_new = '0;
        for (int i = 0; i < NUM_BRICKS; i++)
            n_new = n_new + CW'(newly[i]);
    end

`ifdef BRICK_GAME_BONUS_LIFE_EN
    logic [2:0] bonus_cnt, bonus_next;
    int         bonus_sum, lives_sum;
    // Several bricks may fall together, so the wrap at five is done arithmetically.
    always_comb begin
        bonus_sum = int'(bonus_cnt) + int'(n_new);
        lives_sum = int'(lives) + bonus_sum / 5;
    end
    assign bonus_next = 3'(bonus_sum % 5);
    assign play_lives = lives_sum > 7 ? 3'd7 : 3'(lives_sum);
`else
    assign play_lives = lives;
`endif

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            st            <= IDLE;
            score         <= '0;
            lives         <= '0;
            velocity_x_in <= 2'b11;
            velocity_y_in <= 2'b11;
            ball_reset    <= 1'b0;
            cleared_mask  <= '0;
            brick_prev    <= '1;
            start_prev    <= 1'b0;
            serve_timer   <= '0;
`ifdef BRICK_GAME_BONUS_LIFE_EN
            bonus_cnt     <= '0;
`endif
        end else begin
            start_prev <= start;
            brick_prev <= brick_exists;
            ball_reset <= 1'b0;
            case (st)
                IDLE, OVER, WIN: begin
                    velocity_x_in <= 2'b11;
                    velocity_y_in <= 2'b11;
                    if (start_edge) begin
                        lives        <= 3'(START_LIVES);
                        score        <= '0;
                        cleared_mask <= '0;
                        serve_timer  <= 8'(SERVE_DELAY);
                        ball_reset   <= 1'b1;
                        st           <= SERVE;
`ifdef BRICK_GAME_BONUS_LIFE_EN
                        bonus_cnt    <= '0;
`endif
                    end
                end
                SERVE: begin
                    serve_timer   <= serve_timer - 8'd1;
                    velocity_x_in <= serve_timer == 8'd1 ? 2'b01 : 2'b11;
                    velocity_y_in <= serve_timer == 8'd1 ? 2'b10 : 2'b11;
                    if (serve_timer == 8'd1)
                        st <= PLAY;
                end
                PLAY: begin
                    velocity_x_in <= velocity_x_out;
                    velocity_y_in <= velocity_y_out;
                    cleared_mask  <= cleared_mask | newly;
                    score         <= score_next;
                    lives         <= play_lives;
`ifdef BRICK_GAME_BONUS_LIFE_EN
                    bonus_cnt     <= bonus_next;
`endif
                    if (all_clear)
                        st <= WIN;
                    else if (floor_hit)
                        st <= LOST;
                end
                LOST: begin
                    velocity_x_in <= 2'b11;
                    velocity_y_in <= 2'b11;
                    lives         <= lives - 3'd1;
                    if (lives == 3'd1) begin
                        st <= OVER;
                    end else begin
                        serve_timer <= 8'(SERVE_DELAY);
                        ball_reset  <= 1'b1;
                        st          <= SERVE;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_brick_game_ctrl.sv
// tb_brick_game_ctrl: directed scenarios plus random play checked against a frame-level game model.
module tb_brick_game_ctrl;
    logic        frame_clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  brick_exists = '1;
    logic [9:0]  ball_y = 10'd100;
    logic [9:0]  ball_s = 10'd4;
    logic [1:0]  velocity_x_out = 2'b01, velocity_y_out = 2'b10;
    logic [1:0]  velocity_x_in, velocity_y_in;
    logic        ball_reset, game_over, game_won;
    logic [15:0] score;
    logic [2:0]  lives, state;
    int          checks = 0, fails = 0;

    int          m_state, m_score, m_lives, m_serve, m_bonus;
    logic [1:0]  m_vx, m_vy;
    logic        m_br, m_sprev;
    logic [9:0]  m_cleared, m_bprev;

    localparam logic [28:0] RST_VEC = {3'd0, 16'd0, 3'd0, 2'b11, 2'b11, 1'b0, 1'b0, 1'b0};
`ifdef BRICK_GAME_BONUS_LIFE_EN
    localparam logic [2:0] WIN_LIVES = 3'd5;
`else
    localparam logic [2:0] WIN_LIVES = 3'd3;
`endif

    brick_game_ctrl dut (
        .frame_clk(frame_clk), .Reset_n(Reset_n), .start(start), .brick_exists(brick_exists),
        .ball_y(ball_y), .ball_s(ball_s), .velocity_x_out(velocity_x_out), .velocity_y_out(velocity_y_out),
        .velocity_x_in(velocity_x_in), .velocity_y_in(velocity_y_in), .ball_reset(ball_reset),
        .score(score), .lives(lives), .state(state), .game_over(game_over), .game_won(game_won)
    );

    always #5 frame_clk = ~frame_clk;

    wire [28:0] dut_vec = {state, score, lives, velocity_x_in, velocity_y_in, ball_reset, game_over, game_won};

    function automatic logic [28:0] exp_vec();
        return {3'(m_state), 16'(m_score), 3'(m_lives), m_vx, m_vy, m_br, m_state == 4, m_state == 5};
    endfunction

    function automatic void model_reset();
        m_state = 0; m_score = 0; m_lives = 0; m_serve = 0; m_bonus = 0;
        m_vx = 2'b11; m_vy = 2'b11; m_br = 1'b0; m_sprev = 1'b0;
        m_cleared = '0; m_bprev = '1;
    endfunction

    // One frame of the game rules, evaluated on the inputs present at the coming edge.
    function automatic void model_step();
        logic [9:0] nw;
        int n;
        nw = m_bprev & ~brick_exists & ~m_cleared;
        n = $countones(nw);
        m_br = 1'b0;
        if (m_state == 0 || m_state >= 4) begin
            m_vx = 2'b11; m_vy = 2'b11;
            if (start && !m_sprev) begin
                m_state = 1; m_lives = 3; m_score = 0; m_cleared = '0;
                m_serve = 0; m_bonus = 0; m_br = 1'b1;
            end
        end else if (m_state == 1) begin
            m_serve++;
            m_vx = 2'b11; m_vy = 2'b11;
            if (m_serve == 60) begin m_state = 2; m_vx = 2'b01; m_vy = 2'b10; end
        end else if (m_state == 2) begin
            m_vx = velocity_x_out; m_vy = velocity_y_out;
            m_cleared = m_cleared | nw;
            m_score = (m_score + 10 * n > 65535) ? 65535 : m_score + 10 * n;
`ifdef BRICK_GAME_BONUS_LIFE_EN
            m_bonus += n;
            while (m_bonus >= 5) begin
                m_bonus -= 5;
                if (m_lives < 7) m_lives++;
            end
`endif
            if (m_cleared == 10'h3FF) m_state = 5;
            else if (int'(ball_y) + int'(ball_s) >= 470) m_state = 3;
        end else begin
            m_vx = 2'b11; m_vy = 2'b11;
            if (m_lives == 1) begin m_lives = 0; m_state = 4; end
            else begin m_lives--; m_serve = 0; m_br = 1'b1; m_state = 1; end
        end
        m_bprev = brick_exists;
        m_sprev = start;
    endfunction

    task automatic tick();
        model_step();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic serve_to_play();
        for (int i = 0; i < 300 && m_state == 1; i++) tick();
    endtask

    task automatic start_game();
        brick_exists = '1; start = 1'b1;
        tick();
        start = 1'b0;
        serve_to_play();
    endtask

    task automatic test_reset();
        model_reset();
        @(posedge frame_clk);
        #1;
        checks++;
        if (dut_vec !== RST_VEC) begin fails++; $display("FAIL reset_state: got %h want %h", dut_vec, RST_VEC); end
        Reset_n = 1'b1;
        tick();
        checks++;
        if (dut_vec !== exp_vec()) begin fails++; $display("FAIL idle_hold: got %h want %h", dut_vec, exp_vec()); end
    endtask

    task automatic test_serve();
        int frames;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (state !== 3'd1 || ball_reset !== 1'b1 || dut_vec !== exp_vec())
            begin fails++; $display("FAIL serve_entry: got %h want %h", dut_vec, exp_vec()); end
        frames = (state === 3'd1) ? 1 : 0;
        for (int i = 0; i < 100 && m_state == 1; i++) begin
            tick();
            if (state === 3'd1) frames++;
            checks++;
            if (dut_vec !== exp_vec()) begin fails++; $display("FAIL serve_frame %0d: got %h want %h", i, dut_vec, exp_vec()); end
        end
        checks++;
        if (frames != 60) begin fails++; $display("FAIL serve_length: got %0d want 60", frames); end
        checks++;
        if (state !== 3'd2 || velocity_x_in !== 2'b01 || velocity_y_in !== 2'b10)
            begin fails++; $display("FAIL launch: state %0d vx %b vy %b want 2 01 10", state, velocity_x_in, velocity_y_in); end
    endtask

    task automatic test_scoring();
        brick_exists = 10'h3FC;
        tick();
        checks++;
        if (score !== 16'd20 || dut_vec !== exp_vec()) begin fails++; $display("FAIL score_two: got %0d want 20", score); end
        ball_y = 10'd466;
        tick();
        ball_y = 10'd100;
        tick();
        checks++;
        if (ball_reset !== 1'b1 || lives !== 3'd2 || state !== 3'd1)
            begin fails++; $display("FAIL loss_reserve: br %b lives %0d state %0d want 1 2 1", ball_reset, lives, state); end
        brick_exists = '1;
        serve_to_play();
        brick_exists = 10'h3FC;
        tick();
        checks++;
        if (score !== 16'd20 || dut_vec !== exp_vec()) begin fails++; $display("FAIL score_refall: got %0d want 20", score); end
        brick_exists = 10'h3F8;
        tick();
        checks++;
        if (score !== 16'd30 || lives !== 3'd2) begin fails++; $display("FAIL score_three: score %0d lives %0d want 30 2", score, lives); end
    endtask

    task automatic test_velocity();
        velocity_x_out = 2'b10; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (velocity_x_in !== 2'b10 || state !== 3'd2 || dut_vec !== exp_vec())
            begin fails++; $display("FAIL vel_follow: vx %b state %0d want 10 2", velocity_x_in, state); end
        velocity_x_out = 2'b01;
        tick();
        checks++;
        if (velocity_x_in !== 2'b01) begin fails++; $display("FAIL vel_back: vx %b want 01", velocity_x_in); end
    endtask

    task automatic test_reset_mid();
        checks++;
        if (score !== 16'd30 || lives !== 3'd2 || state !== 3'd2)
            begin fails++; $display("FAIL pre_reset: score %0d lives %0d state %0d want 30 2 2", score, lives, state); end
        Reset_n = 1'b0;
        #1;
        checks++;
        if (dut_vec !== RST_VEC) begin fails++; $display("FAIL reset_mid: got %h want %h", dut_vec, RST_VEC); end
        model_reset();
        @(posedge frame_clk);
        #1;
        Reset_n = 1'b1;
        brick_exists = '1;
    endtask

    task automatic test_lives();
        start_game();
        ball_y = 10'd465;
        tick();
        checks++;
        if (state !== 3'd2 || lives !== 3'd3 || dut_vec !== exp_vec())
            begin fails++; $display("FAIL floor_edge: state %0d lives %0d want 2 3", state, lives); end
        for (int k = 2; k >= 0; k--) begin
            ball_y = 10'd466;
            tick();
            ball_y = 10'd100;
            tick();
            checks++;
            if (lives !== 3'(k) || dut_vec !== exp_vec() ||
                (k > 0 && (ball_reset !== 1'b1 || state !== 3'd1)) ||
                (k == 0 && (state !== 3'd4 || game_over !== 1'b1)))
                begin fails++; $display("FAIL floor_hit %0d: lives %0d state %0d br %b go %b", k, lives, state, ball_reset, game_over); end
            if (k == 2) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                checks++;
                if (state !== 3'd1 || dut_vec !== exp_vec()) begin fails++; $display("FAIL start_in_serve: state %0d want 1", state); end
            end
            if (k > 0) serve_to_play();
        end
    endtask

    task automatic test_win();
        start_game();
        brick_exists = 10'h200;
        tick();
        brick_exists = 10'h000; ball_y = 10'd466;
        tick();
        ball_y = 10'd100;
        checks++;
        if (state !== 3'd5 || game_won !== 1'b1 || lives !== WIN_LIVES || score !== 16'd100)
            begin fails++; $display("FAIL win_over_floor: state %0d won %b lives %0d score %0d", state, game_won, lives, score); end
        tick();
        checks++;
        if (dut_vec !== exp_vec()) begin fails++; $display("FAIL win_hold: got %h want %h", dut_vec, exp_vec()); end
    endtask

`ifdef BRICK_GAME_BONUS_LIFE_EN
    task automatic test_bonus();
        start_game();
        brick_exists = 10'h3E0;
        tick();
        checks++;
        if (lives !== 3'd4 || dut_vec !== exp_vec()) begin fails++; $display("FAIL bonus_life: lives %0d want 4", lives); end
    endtask
`endif

    task automatic test_random();
        for (int f = 0; f < 3000; f++) begin
            start = $urandom_range(0, 29) == 0;
            if (m_br) brick_exists = '1;
            else if ($urandom_range(0, 5) == 0) brick_exists[$urandom_range(0, 9)] = 1'b0;
            else if ($urandom_range(0, 20) == 0) brick_exists[$urandom_range(0, 9)] = 1'b1;
            if ($urandom_range(0, 39) == 0) begin
                ball_y = 10'(460 + $urandom_range(0, 20));
                ball_s = 10'($urandom_range(0, 15));
            end else begin
                ball_y = 10'($urandom_range(0, 400));
                ball_s = 10'($urandom_range(1, 15));
            end
            velocity_x_out = 2'($urandom_range(1, 3));
            velocity_y_out = 2'($urandom_range(1, 3));
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin fails++; $display("FAIL random frame %0d: got %h want %h", f, dut_vec, exp_vec()); end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_serve();
        test_scoring();
        test_velocity();
        test_reset_mid();
        test_lives();
        test_win();
`ifdef BRICK_GAME_BONUS_LIFE_EN
        test_bonus();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
